qam_mod_core: RTL and testbench

Parametrised successor to the fixed 16-QAM modulator. It accepts a serial bit stream through a valid/ready handshake and groups the bits into BITS_PER_SYM-bit symbols. Each symbol is mapped to signed I/Q levels (square M-QAM, optional Gray decoding) and modulated onto an NCO-driven quadrature carrier from a parametrised sine ROM. It feeds the DAC interface, producing one passband sample per clock.

---
 rtl/qam_mod_core.sv | 206 ++++++++++++++++++++
 tb/tb_qam_mod_core.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/qam_mod_core.sv
`timescale 1ns/1ps
// qam_mod_core: serial bits -> square M-QAM I/Q levels -> NCO quadrature upconversion.
// Optional build macro QAM_GRAY_EN: Gray-decode each axis field before level mapping.
module qam_mod_core #(
  parameter int BITS_PER_SYM = 4,
  parameter int SYM_PERIOD   = 16,
  parameter int PHASE_W      = 16,
  parameter int PHASE_INC    = 4096,
  parameter int LUT_AW       = 6,
  parameter int AMP_W        = 10,
  localparam int LVL_W       = BITS_PER_SYM / 2 + 1,
  localparam int MOD_W       = AMP_W + LVL_W + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    bit_in,
  input  logic                    bit_valid,
  output logic                    bit_ready,
  output logic                    sym_strobe,
  output logic signed [LVL_W-1:0] i_level,
  output logic signed [LVL_W-1:0] q_level,
  output logic signed [AMP_W-1:0] sin_out,
  output logic signed [AMP_W-1:0] cos_out,
  output logic signed [MOD_W-1:0] mod_out,
  output logic                    underrun
);

  localparam int  K       = BITS_PER_SYM;
  localparam int  HALF    = K / 2;
  localparam int  M       = 1 << HALF;
  localparam int  N       = 1 << LUT_AW;
  localparam int  CNT_W   = $clog2(K + 1);
  localparam int  SC_W    = (SYM_PERIOD > 2) ? $clog2(SYM_PERIOD) : 1;
  localparam int  AMP_MAX = (1 << (AMP_W - 1)) - 1;
  localparam real PI      = 3.14159265358979323846;

  typedef enum logic [0:0] {
    FILL = 1'b0,
    FULL = 1'b1
  } fill_state_e;

  function automatic logic [N*AMP_W-1:0] rom_init();
    logic [N*AMP_W-1:0] bits;
    real                v;
    int                 r;
    bits = {(N*AMP_W){1'b0}};
    for (int k = 0; k < N; k++) begin
      v = real'(AMP_MAX) * $sin(2.0 * PI * real'(k) / real'(N));
      r = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
      bits[k*AMP_W +: AMP_W] = AMP_W'(r);
    end
    return bits;
  endfunction

  localparam logic [N*AMP_W-1:0] ROM_BITS = rom_init();

`ifdef QAM_GRAY_EN
  function automatic logic [HALF-1:0] gray2bin(input logic [HALF-1:0] g);
    logic [HALF-1:0] b;
    b[HALF-1] = g[HALF-1];
    for (int i = HALF - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction
`endif

  // level = 2*code - (M-1) == (2*code + 1) - M, exact in LVL_W-bit two's complement
  function automatic logic signed [LVL_W-1:0] map_level(input logic [HALF-1:0] field);
    logic [HALF-1:0] code;
`ifdef QAM_GRAY_EN
    code = gray2bin(field);
`else
    code = field;
`endif
    return {code, 1'b1} - LVL_W'(M);
  endfunction

  fill_state_e             state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [K-1:0]            shift_q, shift_d;
  logic [SC_W-1:0]         sym_cnt_q, sym_cnt_d;
  logic                    strobe_q, strobe_d;
  logic                    underrun_q, underrun_d;
  logic signed [LVL_W-1:0] i_lvl_q, i_lvl_d, q_lvl_q, q_lvl_d;
  logic signed [LVL_W-1:0] i_dly_q, q_dly_q;
  logic [PHASE_W-1:0]      phase_q, phase_d;
  logic signed [AMP_W-1:0] sin_q, sin_d, cos_q, cos_d;
  logic signed [MOD_W-1:0] mod_q, mod_d;
  logic signed [MOD_W-1:0] prod_i, prod_q;
  logic [LUT_AW-1:0]       sin_idx, cos_idx;
  logic                    accept;
  logic [K-1:0]            shift_in;

  assign bit_ready = !rst && ((state_q == FILL) || strobe_q);
  assign accept    = bit_valid && bit_ready;
  assign shift_in  = {shift_q[K-2:0], bit_in};

  // Shift-stage FSM next state together with symbol load and underrun detection.
  always_comb begin
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    i_lvl_d    = i_lvl_q;
    q_lvl_d    = q_lvl_q;
    underrun_d = 1'b0;
    case (state_q)
      FULL: begin
        if (strobe_q) begin
          i_lvl_d = map_level(shift_q[K-1 -: HALF]);
          q_lvl_d = map_level(shift_q[HALF-1:0]);
          if (accept) begin
            shift_d = shift_in;
            cnt_d   = CNT_W'(1);
          end else begin
            cnt_d = {CNT_W{1'b0}};
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      FILL: begin
        // A boundary without a complete symbol idles the carrier but keeps partial bits.
        if (strobe_q) begin
          i_lvl_d    = {LVL_W{1'b0}};
          q_lvl_d    = {LVL_W{1'b0}};
          underrun_d = 1'b1;
        end else begin
          underrun_d = 1'b0;
        end
        if (accept) begin
          shift_d = shift_in;
          cnt_d   = cnt_q + CNT_W'(1);
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        cnt_d = {CNT_W{1'b0}};
      end
    endcase
    state_d = (cnt_d == CNT_W'(K)) ? FULL : FILL;
  end

  // Symbol timing, NCO, sine/cosine lookup and mixer datapath.
  always_comb begin
    if (sym_cnt_q == SC_W'(SYM_PERIOD - 1)) begin
      sym_cnt_d = {SC_W{1'b0}};
      strobe_d  = 1'b1;
    end else begin
      sym_cnt_d = sym_cnt_q + SC_W'(1);
      strobe_d  = 1'b0;
    end
    phase_d = phase_q + PHASE_W'(PHASE_INC);
    sin_idx = phase_q[PHASE_W-1 -: LUT_AW];
    cos_idx = sin_idx + LUT_AW'(N / 4);
    sin_d   = ROM_BITS[int'(sin_idx)*AMP_W +: AMP_W];
    cos_d   = ROM_BITS[int'(cos_idx)*AMP_W +: AMP_W];
    prod_i  = MOD_W'(i_dly_q) * MOD_W'(cos_q);
    prod_q  = MOD_W'(q_dly_q) * MOD_W'(sin_q);
    mod_d   = prod_i - prod_q;
  end

  // All state and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FILL;
      cnt_q      <= {CNT_W{1'b0}};
      shift_q    <= {K{1'b0}};
      sym_cnt_q  <= {SC_W{1'b0}};
      strobe_q   <= 1'b0;
      underrun_q <= 1'b0;
      i_lvl_q    <= {LVL_W{1'b0}};
      q_lvl_q    <= {LVL_W{1'b0}};
      i_dly_q    <= {LVL_W{1'b0}};
      q_dly_q    <= {LVL_W{1'b0}};
      phase_q    <= {PHASE_W{1'b0}};
      sin_q      <= {AMP_W{1'b0}};
      cos_q      <= {AMP_W{1'b0}};
      mod_q      <= {MOD_W{1'b0}};
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      sym_cnt_q  <= sym_cnt_d;
      strobe_q   <= strobe_d;
      underrun_q <= underrun_d;
      i_lvl_q    <= i_lvl_d;
      q_lvl_q    <= q_lvl_d;
      i_dly_q    <= i_lvl_q;
      q_dly_q    <= q_lvl_q;
      phase_q    <= phase_d;
      sin_q      <= sin_d;
      cos_q      <= cos_d;
      mod_q      <= mod_d;
    end
  end

  assign sym_strobe = strobe_q;
  assign underrun   = underrun_q;
  assign i_level    = i_lvl_q;
  assign q_level    = q_lvl_q;
  assign sin_out    = sin_q;
  assign cos_out    = cos_q;
  assign mod_out    = mod_q;

endmodule

// File: tb/tb_qam_mod_core.sv
`timescale 1ns/1ps
// Randomised self-checking bench for qam_mod_core: a queue-based symbol model for the
// 16-QAM instance plus literal checks on a second 64-QAM instance.
module tb_qam_mod_core;

  localparam int K = 4, SP = 16, PW = 16, INC = 4096, LAW = 6, AW = 10;
  localparam int LVW = 3, MW = 14, LVW6 = 4, MW6 = 15;
  localparam int NROM = 64;

`ifdef QAM_GRAY_EN
  localparam int P1_I = 3, P1_Q = 1, P2_I = -1, P2_Q = 3, I6 = 3, MOD6 = 1533;
`else
  localparam int P1_I = 1, P1_Q = 3, P2_I = -1, P2_Q = 1, I6 = 7, MOD6 = 3577;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, bit_in, bit_valid, bit_ready, sym_strobe, underrun;
  logic signed [LVW-1:0] i_level, q_level;
  logic signed [AW-1:0]  sin_out, cos_out;
  logic signed [MW-1:0]  mod_out;

  logic rst6, bit_in6, bit_valid6, bit_ready6, sym_strobe6, underrun6;
  logic signed [LVW6-1:0] i_level6, q_level6;
  logic signed [AW-1:0]   sin_out6, cos_out6;
  logic signed [MW6-1:0]  mod_out6;

  qam_mod_core dut (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .bit_ready(bit_ready),
    .sym_strobe(sym_strobe), .i_level(i_level), .q_level(q_level),
    .sin_out(sin_out), .cos_out(cos_out), .mod_out(mod_out), .underrun(underrun)
  );

  qam_mod_core #(.BITS_PER_SYM(6)) dut6 (
    .clk(clk), .rst(rst6), .bit_in(bit_in6), .bit_valid(bit_valid6), .bit_ready(bit_ready6),
    .sym_strobe(sym_strobe6), .i_level(i_level6), .q_level(q_level6),
    .sin_out(sin_out6), .cos_out(cos_out6), .mod_out(mod_out6), .underrun(underrun6)
  );

  int errors = 0;
  int checks = 0;

  function automatic void chk(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  int rom [NROM];

  function automatic int gray_dec(int g);
    int b = 0;
    for (int s = g; s != 0; s = s >> 1) b = b ^ s;
    return b;
  endfunction

  function automatic int level_of(int field, int half);
    int code = field;
`ifdef QAM_GRAY_EN
    code = gray_dec(field);
`endif
    return 2 * code - ((1 << half) - 1);
  endfunction

  // Model state: cycles since reset release, buffered bits, active levels and pipeline
  int     t = 0;
  bit     bq [$];
  int     lvl_i = 0, lvl_q = 0, id_m = 0, qd_m = 0, und_m = 0;
  longint mod_m = 0;
  int     pin_sel = 1;
  bit     bp_active = 1'b0;
  bit     bp_started = 1'b0;
  int     acc_win = 0;

  always @(negedge clk) begin
    int e_sin, e_cos, ph, idx, sym;
    bit e_stb, e_rdy, acc;
    if (t == 0) begin
      e_sin = 0;
      e_cos = 0;
    end else begin
      ph    = ((t - 1) * INC) & ((1 << PW) - 1);
      idx   = ph >> (PW - LAW);
      e_sin = rom[idx];
      e_cos = rom[(idx + NROM / 4) % NROM];
    end
    e_stb = (t > 0) && (t % SP == 0);
    e_rdy = !rst && ((bq.size() < K) || e_stb);

    chk("sin_out", sin_out, e_sin);
    chk("cos_out", cos_out, e_cos);
    chk("sym_strobe", sym_strobe, e_stb);
    chk("bit_ready", bit_ready, e_rdy);
    chk("i_level", i_level, lvl_i);
    chk("q_level", q_level, lvl_q);
    chk("underrun", underrun, und_m);
    chk("mod_out", mod_out, mod_m);

    if (pin_sel == 1) begin
      if (t == 1) begin
        chk("pin_first_cos", cos_out, 511);
        chk("pin_first_sin", sin_out, 0);
      end
      if (t == 15) chk("pin_no_early_strobe", sym_strobe, 0);
      if (t == 16) chk("pin_first_strobe", sym_strobe, 1);
      if (t == 17) begin
        chk("pin_1011_i", i_level, P1_I);
        chk("pin_1011_q", q_level, P1_Q);
      end
      if (t == 33) chk("pin_underrun_pulse", underrun, 1);
      if (t == 34) chk("pin_underrun_width", underrun, 0);
      if (t == 40) begin
        chk("pin_underrun_i", i_level, 0);
        chk("pin_underrun_mod", mod_out, 0);
      end
    end
    if (pin_sel == 2 && t == 17) begin
      chk("pin_fresh_i", i_level, P2_I);
      chk("pin_fresh_q", q_level, P2_Q);
    end

    if (!bp_active) begin
      bp_started = 1'b0;
      acc_win    = 0;
    end else begin
      if (e_stb) begin
        if (bp_started) chk("bp_accepts_per_symbol", acc_win, 4);
        bp_started = 1'b1;
        acc_win    = 0;
      end
      if (bit_valid && bit_ready) acc_win++;
    end

    acc = bit_valid && e_rdy;
    if (rst) begin
      t = 0; bq.delete(); lvl_i = 0; lvl_q = 0; id_m = 0; qd_m = 0; und_m = 0; mod_m = 0;
    end else begin
      mod_m = longint'(id_m) * e_cos - longint'(qd_m) * e_sin;
      id_m  = lvl_i;
      qd_m  = lvl_q;
      und_m = 0;
      if (e_stb) begin
        if (bq.size() == K) begin
          sym = 0;
          foreach (bq[j]) sym = sym * 2 + int'(bq[j]);
          bq.delete();
          lvl_i = level_of(sym >> (K / 2), K / 2);
          lvl_q = level_of(sym & ((1 << (K / 2)) - 1), K / 2);
        end else begin
          lvl_i = 0;
          lvl_q = 0;
          und_m = 1;
        end
      end
      if (acc) bq.push_back(bit_in);
      t++;
    end
  end

  int t6 = 0;

  always @(negedge clk) begin
    if (t6 == 1) chk("q64_first_cos", cos_out6, 511);
    if (t6 == 3) chk("q64_sin_eighth", sin_out6, 361);
    if (t6 == 7) chk("q64_ready_full", bit_ready6, 0);
    if (t6 == 16) chk("q64_strobe", sym_strobe6, 1);
    if (t6 == 17) begin
      chk("q64_i_level", i_level6, I6);
      chk("q64_q_level", q_level6, -7);
    end
    if (t6 == 33) begin
      chk("q64_underrun", underrun6, 1);
      chk("q64_idle_i", i_level6, 0);
    end
    if (t6 == 34) chk("q64_mod_zero_phase", mod_out6, MOD6);
    t6 = rst6 ? 0 : t6 + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit b4 [4];
    bit b6 [6];
    bit f4 [4];
    real v;
    b4 = '{1'b1, 1'b0, 1'b1, 1'b1};
    b6 = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    f4 = '{1'b0, 1'b1, 1'b1, 1'b0};
    rst = 1'b1; rst6 = 1'b1;
    bit_in = 1'b0; bit_valid = 1'b0; bit_in6 = 1'b0; bit_valid6 = 1'b0;
    for (int k = 0; k < NROM; k++) begin
      v = 511.0 * $sin(2.0 * 3.14159265358979 * k / NROM);
      rom[k] = $rtoi($floor(v + 0.5));
    end
    chk("model_rom_8", rom[8], 361);
    chk("model_rom_16", rom[16], 511);
    chk("model_rom_48", rom[48], -511);

    repeat (5) step();
    rst = 1'b0; rst6 = 1'b0;
    for (int j = 0; j < 6; j++) begin
      bit_valid  = (j < 4);
      bit_in     = (j < 4) ? b4[j] : 1'b0;
      bit_valid6 = 1'b1;
      bit_in6    = b6[j];
      step();
    end
    bit_valid = 1'b0; bit_valid6 = 1'b0;
    repeat (60) step();
    pin_sel = 0;

    bp_active = 1'b1;
    bit_valid = 1'b1;
    repeat (160) begin
      bit_in = 1'($urandom);
      step();
    end
    bp_active = 1'b0;
    bit_valid = 1'b0;

    repeat (300) begin
      bit_valid = ($urandom_range(0, 3) != 0);
      bit_in    = 1'($urandom);
      step();
    end

    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    bit_valid = 1'b0;
    repeat ($urandom_range(3, 9)) step();
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    bit_valid = 1'b1;
    bit_in = 1'b1; step();
    bit_in = 1'b1; step();
    bit_valid = 1'b0;
    rst = 1'b1;
    repeat (3) step();
    pin_sel = 2;
    rst = 1'b0;
    for (int j = 0; j < 4; j++) begin
      bit_valid = 1'b1;
      bit_in    = f4[j];
      step();
    end
    bit_valid = 1'b0;
    repeat (40) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
